hilo_muldiv_ctrl: RTL

Sequencer for the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and runs either a pipelined multiply or a 32-iteration radix-2 restoring divide. It then drives the HILO write ports (wen_HI/wHI, wen_LO/wLO) for exactly one cycle per completed operation. It also provides the busy/ready handshake the pipeline uses to stall, and a flush input that cancels an in-flight operation on an exception.

---
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/hilo_muldiv_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_if.sv
// EX-stage <-> HI/LO sequencer bus: request handshake, flush, and the HI/LO write ports.
// The master drives requests and flush; the slave returns ready/busy/done and write data.
interface hilo_muldiv_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        busy;
    logic        done;
    logic        wen_HI;
    logic [31:0] wHI;
    logic        wen_LO;
    logic [31:0] wLO;

    modport master (
        output req_valid, req_op, req_src1, req_src2, flush,
        input  req_ready, busy, done, wen_HI, wHI, wen_LO, wLO
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, flush,
        output req_ready, busy, done, wen_HI, wHI, wen_LO, wLO
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: MT ops and divide-by-zero write 1 cycle after accept, MULT/MULTU after MUL_STAGES+1, DIV/DIVU after 33.
// req_ready is low whenever busy or flushing; flush drops any in-flight op and suppresses its write.
module hilo_muldiv_ctrl #(
    parameter int MUL_STAGES = 1,
    parameter int DIV_ITERS  = 32
) (
    input  logic         clk,
    input  logic         resetn,
    hilo_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int CNT_MAX = (MUL_STAGES > DIV_ITERS) ? MUL_STAGES : DIV_ITERS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        a_q;      // multiplicand, or dividend magnitude shifting into quotient
    logic [31:0]        b_q;      // multiplier, or divisor magnitude
    logic [31:0]        rem_q;
    logic               sgn_q;
    logic               neg_q;
    logic               neg_r;
    logic               hi_en;
    logic               lo_en;
    logic [31:0]        whi_q;
    logic [31:0]        wlo_q;

    logic               accept;
    logic               sdiv;
    logic [31:0]        mag1;
    logic [31:0]        mag2;
    logic [63:0]        a_ext;
    logic [63:0]        b_ext;
    logic [63:0]        prod;
    logic [32:0]        rem_sh;
    logic [31:0]        sub;
    logic               q_bit;
    logic [31:0]        rem_nx;
    logic [31:0]        quo_nx;

    assign bus.req_ready = (state == IDLE) & ~bus.flush;
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == WB) & ~bus.flush;
    assign bus.wen_HI    = bus.done & hi_en;
    assign bus.wen_LO    = bus.done & lo_en;
    assign bus.wHI       = whi_q;
    assign bus.wLO       = wlo_q;

    always_comb begin
        sdiv   = (bus.req_op == OP_DIV);
        mag1   = (sdiv && bus.req_src1[31]) ? -bus.req_src1 : bus.req_src1;
        mag2   = (sdiv && bus.req_src2[31]) ? -bus.req_src2 : bus.req_src2;
        a_ext  = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        b_ext  = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod   = a_ext * b_ext;
        // Restoring step: shift in the next dividend bit, subtract if it fits.
        rem_sh = {rem_q, a_q[31]};
        q_bit  = (rem_sh >= {1'b0, b_q});
        sub    = rem_sh[31:0] - b_q;
        rem_nx = q_bit ? sub : rem_sh[31:0];
        quo_nx = {a_q[30:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_en <= 1'b0;
            lo_en <= 1'b0;
            whi_q <= '0;
            wlo_q <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        rem_q <= '0;
                        case (bus.req_op)
                            OP_MTHI: begin
                                whi_q <= bus.req_src1;
                                hi_en <= 1'b1;
                                lo_en <= 1'b0;
                                state <= WB;
                            end
                            OP_MTLO: begin
                                wlo_q <= bus.req_src1;
                                hi_en <= 1'b0;
                                lo_en <= 1'b1;
                                state <= WB;
                            end
                            OP_MULT, OP_MULTU: begin
                                a_q   <= bus.req_src1;
                                b_q   <= bus.req_src2;
                                sgn_q <= (bus.req_op == OP_MULT);
                                hi_en <= 1'b1;
                                lo_en <= 1'b1;
                                state <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                hi_en <= 1'b1;
                                lo_en <= 1'b1;
                                if (bus.req_src2 == 32'd0) begin
                                    whi_q <= bus.req_src1;
                                    wlo_q <= 32'hFFFF_FFFF;
                                    state <= WB;
                                end else begin
                                    a_q   <= mag1;
                                    b_q   <= mag2;
                                    neg_q <= sdiv & (bus.req_src1[31] ^ bus.req_src2[31]);
                                    neg_r <= sdiv & bus.req_src1[31];
                                    state <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt == MUL_LAST) begin
                        whi_q <= prod[63:32];
                        wlo_q <= prod[31:0];
                        cnt   <= '0;
                        state <= WB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    a_q   <= quo_nx;
                    rem_q <= rem_nx;
                    if (cnt == DIV_LAST) begin
                        whi_q <= neg_r ? -rem_nx : rem_nx;
                        wlo_q <= neg_q ? -quo_nx : quo_nx;
                        cnt   <= '0;
                        state <= WB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
